mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch (IF) requester and the data-access (MEM stage) requester.
- Sequences each access through a ready-handshake memory port and returns read data to the owning requester.
- Drives a registered pipeline stall while a data access is pending.
- Sits between the pipeline stages and the memory model/controller, alongside the stall controller.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; byte-enable width is DW/8.
- TIMEOUT_CYCLES, 255, maximum wait for i_mem_ready. Used only with MEM_ARB_TIMEOUT_EN. Counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_if_req  in  1  fetch request; held high until o_if_valid.
- i_if_addr  in  AW  fetch address.
- i_flush  in  1  branch taken; discard the pending or in-flight fetch.
- i_d_req  in  1  data request; held high until o_d_valid.
- i_d_we  in  1  data write enable.
- i_d_addr  in  AW  data address.
- i_d_wdata  in  DW  write data.
- i_d_be  in  DW/8  byte enables.
- o_if_valid  out  1  one-cycle pulse; o_if_rdata is valid.
- o_if_rdata  out  DW  fetched word.
- o_d_valid  out  1  one-cycle pulse; data access is complete.
- o_d_rdata  out  DW  read data; 0 for writes.
- o_stall_r  out  1  pipeline stall request.
- o_err  out  1  one-cycle pulse marking a timed-out access; tied 0 without the optional feature.
- o_mem_req  out  1  memory request; held until i_mem_ready.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  AW  memory address.
- o_mem_wdata  out  DW  memory write data.
- o_mem_be  out  DW/8  memory byte enables.
- i_mem_ready  in  1  access complete this cycle; i_mem_rdata is valid.
- i_mem_rdata  in  DW  memory read data.

Behaviour:
- Reset: asynchronous. FSM goes to IDLE. All outputs are 0, including rdata registers and the flush-pending flag.
- FSM states: IDLE, BUSY_D, BUSY_IF.
- Arbitration: in IDLE, or in a BUSY state on the i_mem_ready cycle, select the next grant.
  - i_d_req has priority over i_if_req.
  - The grant is fixed priority, with no round-robin.
  - Enter BUSY_D or BUSY_IF, or go to IDLE if nothing is requesting.
- Issue: on the grant edge, register the request fields into the o_mem_* outputs and set o_mem_req=1.
  - A request sampled at cycle N gives o_mem_req=1 at N+1.
  - The o_mem_* outputs stay stable until i_mem_ready is sampled.
  - Back-to-back accesses have no idle bubble: on the ready cycle, the next grant's o_mem_* values are loaded directly.
- Completion: i_mem_ready sampled high at cycle M gives, at M+1:
  - a o_d_valid or o_if_valid pulse for exactly 1 cycle;
  - rdata captured from i_mem_rdata, or o_d_rdata=0 for a write.
  - i_mem_ready while o_mem_req=0 is ignored.
- The o_*_rdata outputs hold their value until the next completion for that requester.
- A requester that deasserts its req before being granted is dropped silently. After the grant, deasserting req has no effect: the access completes.
- Flush:
  - i_flush in IDLE, or while the fetch is not yet granted: no fetch is issued that cycle.
  - i_flush during BUSY_IF: the memory access completes normally, o_if_valid is suppressed, and o_if_rdata is unchanged.
  - Data accesses are never affected by i_flush.
  - i_flush together with a new i_if_req on the same cycle: the request is discarded. The requester must re-present it on the next cycle.
- Stall:
  - o_stall_r is set on the edge after i_d_req is sampled high with no data access in progress.
  - It stays high through BUSY_D.
  - It clears on the same edge that raises o_d_valid.
  - A data request waiting behind BUSY_IF also keeps o_stall_r high.
- Reset during an access: the in-flight access is abandoned and o_mem_req drops asynchronously. The memory side must tolerate this.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - a wait counter clears on each issue and increments every BUSY cycle without i_mem_ready;
  - on reaching TIMEOUT_CYCLES, o_mem_req drops and the FSM returns to arbitration;
  - the owning requester receives the valid pulse with rdata=0 and o_err=1 on the same cycle;
  - o_stall_r clears as on normal completion.
- When undefined: no counter is built, the FSM waits indefinitely, and o_err is constant 0.

Test Plan:
- Fetch read: i_if_req=1, addr=0x100; memory returns ready 2 cycles after o_mem_req with rdata 0xDEADBEEF -> o_if_valid pulses 1 cycle after ready, o_if_rdata=0xDEADBEEF, o_stall_r stays 0.
- Simultaneous request: i_if_req and i_d_req both asserted at cycle 0, data is a read of 0x200 -> data issued first at cycle 1; o_stall_r=1 from cycle 1 until the o_d_valid edge; fetch issued on the edge after data ready, with no idle cycle between them.
- Data write: we=1, be=0b0011, wdata=0x12345678 -> o_mem_we=1, o_mem_be=0b0011; o_d_valid pulses with o_d_rdata=0.
- Flush in flight: i_flush pulsed while in BUSY_IF -> memory handshake completes, no o_if_valid, o_if_rdata keeps its previous value; a following fetch of 0x300 completes normally.
- Reset mid-access: rst asserted while o_mem_req=1 -> all outputs 0 immediately, without waiting for a clock edge; after release with no requests, FSM is IDLE and no stray valid pulse appears.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: i_mem_ready held 0 on a data read -> o_mem_req drops after 4 wait cycles; o_d_valid=1 and o_err=1 on the same cycle, o_d_rdata=0, o_stall_r cleared.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// requester and the data-access requester. Data has fixed priority over
// fetch, each access runs through a ready handshake, and read data is
// returned to whichever requester owned the access.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access that waits
// TIMEOUT_CYCLES cycles without i_mem_ready and flag it on o_err.
module mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_if_req,
    input  logic [AW-1:0]   i_if_addr,
    input  logic            i_flush,
    input  logic            i_d_req,
    input  logic            i_d_we,
    input  logic [AW-1:0]   i_d_addr,
    input  logic [DW-1:0]   i_d_wdata,
    input  logic [DW/8-1:0] i_d_be,
    output logic            o_if_valid,
    output logic [DW-1:0]   o_if_rdata,
    output logic            o_d_valid,
    output logic [DW-1:0]   o_d_rdata,
    output logic            o_stall_r,
    output logic            o_err,
    output logic            o_mem_req,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_be,
    input  logic            i_mem_ready,
    input  logic [DW-1:0]   i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_D  = 2'd1,
        BUSY_IF = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    state_t state;
    state_t state_n;
    logic   flush_pend;   // a flush arrived while the current fetch was in flight
    logic   timeout;      // current access gave up waiting for i_mem_ready
    logic   mem_done;     // current access ends on this edge (ready or timeout)
    logic   arb;          // a new grant is chosen on this edge
    logic   d_ok;         // data request eligible for a grant
    logic   if_ok;        // fetch request eligible for a grant

    // Next-grant selection: data first, then fetch, otherwise back to idle.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and no latch is inferred.
        mem_done = 1'b0;
        arb      = 1'b0;
        d_ok     = 1'b0;
        if_ok    = 1'b0;
        state_n  = state;

        mem_done = (state != IDLE) && (i_mem_ready || timeout);
        arb      = (state == IDLE) || mem_done;

        // A requester keeps req high until it sees its valid pulse, so it is
        // masked on its own completion edge and during its valid cycle to
        // avoid re-issuing the access that just finished.
        d_ok  = i_d_req && !o_d_valid && !((state == BUSY_D) && mem_done);
        if_ok = i_if_req && !i_flush && !o_if_valid
                && !((state == BUSY_IF) && mem_done);

        if (arb) begin
            if (d_ok) begin
                state_n = BUSY_D;
            end else if (if_ok) begin
                state_n = BUSY_IF;
            end else begin
                state_n = IDLE;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    assign timeout = (state != IDLE) && !i_mem_ready
                     && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Wait counter: cleared on every grant, counts busy cycles without ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            o_err    <= 1'b0;
        end else begin
            o_err <= timeout;
            if (arb) begin
                wait_cnt <= '0;
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign o_err   = 1'b0;
`endif

    // Main sequencer: state, memory port, completions and stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            flush_pend  <= 1'b0;
            o_if_valid  <= 1'b0;
            o_if_rdata  <= '0;
            o_d_valid   <= 1'b0;
            o_d_rdata   <= '0;
            o_stall_r   <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop here samples the pre-edge value of the others.
            state      <= state_n;
            o_if_valid <= 1'b0;
            o_d_valid  <= 1'b0;

            // Completion: pulse the owner's valid and capture its read data.
            if (mem_done) begin
                if (state == BUSY_D) begin
                    o_d_valid <= 1'b1;
                    o_d_rdata <= (o_mem_we || timeout) ? '0 : i_mem_rdata;
                end else if (!(flush_pend || i_flush)) begin
                    o_if_valid <= 1'b1;
                    o_if_rdata <= timeout ? '0 : i_mem_rdata;
                end
            end

            // A flushed fetch still finishes its handshake, but silently.
            if (mem_done || (state != BUSY_IF)) begin
                flush_pend <= 1'b0;
            end else if (i_flush) begin
                flush_pend <= 1'b1;
            end

            // Issue: load the memory port directly from the new grant so
            // back-to-back accesses need no idle cycle in between.
            if (arb) begin
                o_mem_req <= (state_n != IDLE);
                if (state_n == BUSY_D) begin
                    o_mem_we    <= i_d_we;
                    o_mem_addr  <= i_d_addr;
                    o_mem_wdata <= i_d_wdata;
                    o_mem_be    <= i_d_be;
                end else if (state_n == BUSY_IF) begin
                    o_mem_we    <= 1'b0;
                    o_mem_addr  <= i_if_addr;
                    o_mem_wdata <= '0;
                    o_mem_be    <= '1;
                end
            end

            // Stall while a data access is waiting or in flight; it drops on
            // the same edge that raises o_d_valid.
            o_stall_r <= d_ok || (state_n == BUSY_D);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter. The bench plays both
// requesters and the memory; a per-cycle monitor checks every issue,
// completion, stall and error output against expectations queued by the
// stimulus, and the directed sequences pin key values with literals.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          i_flush;
    logic          i_d_req;
    logic          i_d_we;
    logic [AW-1:0] i_d_addr;
    logic [DW-1:0] i_d_wdata;
    logic [BW-1:0] i_d_be;
    logic          o_if_valid;
    logic [DW-1:0] o_if_rdata;
    logic          o_d_valid;
    logic [DW-1:0] o_d_rdata;
    logic          o_stall_r;
    logic          o_err;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [BW-1:0] o_mem_be;
    logic          i_mem_ready;
    logic [DW-1:0] i_mem_rdata;

    mem_arbiter #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_if_req   (i_if_req),
        .i_if_addr  (i_if_addr),
        .i_flush    (i_flush),
        .i_d_req    (i_d_req),
        .i_d_we     (i_d_we),
        .i_d_addr   (i_d_addr),
        .i_d_wdata  (i_d_wdata),
        .i_d_be     (i_d_be),
        .o_if_valid (o_if_valid),
        .o_if_rdata (o_if_rdata),
        .o_d_valid  (o_d_valid),
        .o_d_rdata  (o_d_rdata),
        .o_stall_r  (o_stall_r),
        .o_err      (o_err),
        .o_mem_req  (o_mem_req),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_mem_be   (o_mem_be),
        .i_mem_ready(i_mem_ready),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_d;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } iss_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } cmp_t;

    int n_checks = 0;
    int n_pass   = 0;

    iss_t iss_q[$];          // expected memory issues, in grant order
    cmp_t d_q[$];            // expected data completions
    cmp_t if_q[$];           // expected fetch completions
    iss_t cur;               // issue currently on the memory port
    logic [DW-1:0] mem_img [logic [AW-1:0]];

    int   mem_lat  = 2;      // cycles the memory waits before ready
    logic mem_hold = 1'b0;   // memory never answers while set
    int   wcnt     = 0;
    logic last_req = 1'b0;
    logic d_req_q  = 1'b0;   // i_d_req as sampled by the last rising edge
    logic [DW-1:0] wmerge;
    cmp_t mon_c;
    logic err_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem_img.exists(a) ? mem_img[a] : '0;
    endfunction

    task automatic exp_issue(input logic is_d, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [BW-1:0] be);
        iss_q.push_back({is_d, we, addr, wdata, be});
    endtask

    // Fetch requester: hold req until o_if_valid, report cycles waited.
    task automatic fetch(input logic [AW-1:0] addr, output int cycles);
        logic got;
        got = 1'b0;
        cycles = 0;
        if_q.push_back({mem_rd(addr), 1'b0});
        @(negedge clk);
        i_if_req  = 1'b1;
        i_if_addr = addr;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            cycles = n + 1;
            if (o_if_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("fetch_wait_bound", 0, 1);
        i_if_req = 1'b0;
    endtask

    // Data requester: hold req until o_d_valid.
    task automatic d_access(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [BW-1:0] be, input logic exp_err);
        logic got;
        got = 1'b0;
        d_q.push_back({(we || exp_err) ? '0 : mem_rd(addr), exp_err});
        @(negedge clk);
        i_d_req   = 1'b1;
        i_d_we    = we;
        i_d_addr  = addr;
        i_d_wdata = wdata;
        i_d_be    = be;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (o_d_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("data_wait_bound", 0, 1);
        i_d_req = 1'b0;
    endtask

    always @(posedge clk) d_req_q <= i_d_req;

    // Monitor and memory model, both evaluated away from the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            i_mem_ready = 1'b0;
            i_mem_rdata = '0;
            wcnt        = 0;
            last_req    = 1'b0;
            mem_img.delete();
            mem_img[32'h100] = 32'hDEADBEEF;
            mem_img[32'h104] = 32'h0BADF00D;
            mem_img[32'h200] = 32'hCAFEF00D;
            mem_img[32'h300] = 32'h30303030;
            mem_img[32'h400] = 32'hAABBCCDD;
            mem_img[32'h500] = 32'h55555555;
            mem_img[32'h600] = 32'h66666666;
        end else begin
            // Issue: a request visible now that was not on the port before
            // the edge, or that replaced one completed at the edge.
            if (o_mem_req && (!last_req || i_mem_ready)) begin
                wcnt = 0;
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                    cur = {1'b0, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be};
                end else begin
                    cur = iss_q.pop_front();
                end
            end
            if (o_mem_req) begin
                check("mem_addr", o_mem_addr, cur.addr);
                check("mem_we", o_mem_we, cur.we);
                if (cur.is_d) check("mem_be", o_mem_be, cur.be);
                if (cur.is_d && cur.we) check("mem_wdata", o_mem_wdata, cur.wdata);
            end

            err_exp = 1'b0;
            if (o_d_valid) begin
                if (d_q.size() == 0) check("d_valid_unexpected", 1, 0);
                else begin
                    mon_c = d_q.pop_front();
                    check("d_rdata", o_d_rdata, mon_c.rdata);
                    err_exp = mon_c.err;
                end
            end
            if (o_if_valid) begin
                if (if_q.size() == 0) check("if_valid_unexpected", 1, 0);
                else begin
                    mon_c = if_q.pop_front();
                    check("if_rdata", o_if_rdata, mon_c.rdata);
                    err_exp = err_exp | mon_c.err;
                end
            end
            check("err", o_err, err_exp);
            check("stall", o_stall_r, d_req_q && !o_d_valid);

            // Memory: answer after mem_lat waiting cycles, one-cycle ready.
            last_req = o_mem_req;
            if (i_mem_ready) begin
                i_mem_ready = 1'b0;
                i_mem_rdata = 32'hBAD0BAD0;
            end else if (o_mem_req && !mem_hold) begin
                if (wcnt >= mem_lat) begin
                    if (o_mem_we) begin
                        wmerge = mem_rd(o_mem_addr);
                        for (int b = 0; b < BW; b++)
                            if (o_mem_be[b]) wmerge[8*b +: 8] = o_mem_wdata[8*b +: 8];
                        mem_img[o_mem_addr] = wmerge;
                        i_mem_rdata = 32'hBAD0BAD0;
                    end else begin
                        i_mem_rdata = mem_rd(o_mem_addr);
                    end
                    i_mem_ready = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        logic got;
        int  cnt;

        rst       = 1'b1;
        i_if_req  = 1'b0;
        i_if_addr = '0;
        i_flush   = 1'b0;
        i_d_req   = 1'b0;
        i_d_we    = 1'b0;
        i_d_addr  = '0;
        i_d_wdata = '0;
        i_d_be    = '0;

        repeat (3) @(negedge clk);
        check("rst_mem_req", o_mem_req, 0);
        check("rst_valids", {o_if_valid, o_d_valid}, 0);
        check("rst_stall_err", {o_stall_r, o_err}, 0);
        check("rst_if_rdata", o_if_rdata, 0);
        check("rst_d_rdata", o_d_rdata, 0);
        check("rst_mem_fields", {o_mem_we, o_mem_be, o_mem_addr}, 0);
        rst = 1'b0;

        // Fetch read with a two-cycle memory.
        mem_lat = 2;
        exp_issue(1'b0, 1'b0, 32'h100, '0, '0);
        fetch(32'h100, cyc);
        check("t1_if_rdata", o_if_rdata, 32'hDEADBEEF);
        check("t1_latency", cyc, 4);
        check("t1_no_stall", o_stall_r, 0);

        // Simultaneous data read and fetch: data first, fetch back-to-back.
        exp_issue(1'b1, 1'b0, 32'h200, '0, 4'hF);
        exp_issue(1'b0, 1'b0, 32'h104, '0, '0);
        fork
            d_access(1'b0, 32'h200, '0, 4'hF, 1'b0);
            fetch(32'h104, cyc);
            begin
                @(negedge clk);
                @(negedge clk);
                check("t2_first_addr", o_mem_addr, 32'h200);
                check("t2_stall_set", o_stall_r, 1);
                got = 1'b0;
                for (int n = 0; n < 50; n++) begin
                    if (o_d_valid) begin
                        got = 1'b1;
                        break;
                    end
                    @(negedge clk);
                end
                check("t2_d_done", got, 1);
                check("t2_b2b_req", o_mem_req, 1);
                check("t2_b2b_addr", o_mem_addr, 32'h104);
                check("t2_stall_clear", o_stall_r, 0);
            end
        join
        check("t2_d_rdata", o_d_rdata, 32'hCAFEF00D);
        check("t2_if_rdata", o_if_rdata, 32'h0BADF00D);

        // Partial write, then read it back.
        exp_issue(1'b1, 1'b1, 32'h400, 32'h12345678, 4'b0011);
        d_access(1'b1, 32'h400, 32'h12345678, 4'b0011, 1'b0);
        check("t3_write_rdata", o_d_rdata, 0);
        exp_issue(1'b1, 1'b0, 32'h400, '0, 4'hF);
        d_access(1'b0, 32'h400, '0, 4'hF, 1'b0);
        check("t3_readback", o_d_rdata, 32'hAABB5678);

        // Flush together with a new fetch request: nothing is issued.
        @(negedge clk);
        i_if_req  = 1'b1;
        i_if_addr = 32'h500;
        i_flush   = 1'b1;
        @(negedge clk);
        check("t4_no_issue", o_mem_req, 0);
        i_if_req = 1'b0;
        i_flush  = 1'b0;

        // Flush while the fetch is in flight: handshake ends, no valid.
        mem_lat = 4;
        exp_issue(1'b0, 1'b0, 32'h500, '0, '0);
        @(negedge clk);
        i_if_req  = 1'b1;
        i_if_addr = 32'h500;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (o_mem_req) begin
                got = 1'b1;
                break;
            end
        end
        check("t5_fetch_issued", got, 1);
        i_flush  = 1'b1;
        i_if_req = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        for (int n = 0; n < 20 && o_mem_req; n++) @(negedge clk);
        check("t5_handshake_done", o_mem_req, 0);
        repeat (2) @(negedge clk);
        check("t5_rdata_kept", o_if_rdata, 32'h0BADF00D);
        mem_lat = 1;
        exp_issue(1'b0, 1'b0, 32'h300, '0, '0);
        fetch(32'h300, cyc);
        check("t5_refetch", o_if_rdata, 32'h30303030);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: access aborts after four waiting cycles.
        mem_hold = 1'b1;
        exp_issue(1'b1, 1'b0, 32'h600, '0, 4'hF);
        fork
            d_access(1'b0, 32'h600, '0, 4'hF, 1'b1);
            begin
                cnt = 0;
                for (int n = 0; n < 40; n++) begin
                    @(negedge clk);
                    if (o_mem_req) cnt++;
                    if (o_d_valid) break;
                end
                check("t7_req_cycles", cnt, 4);
                check("t7_err", o_err, 1);
                check("t7_rdata", o_d_rdata, 0);
                check("t7_stall", o_stall_r, 0);
            end
        join
        mem_hold = 1'b0;
        @(negedge clk);
`endif

        // Reset in the middle of a data access.
        mem_hold = 1'b1;
        exp_issue(1'b1, 1'b0, 32'h700, '0, 4'hF);
        @(negedge clk);
        i_d_req  = 1'b1;
        i_d_we   = 1'b0;
        i_d_addr = 32'h700;
        i_d_be   = 4'hF;
        repeat (3) @(negedge clk);
        check("t6_req_before", o_mem_req, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_mem_req", o_mem_req, 0);
        check("t6_async_stall", o_stall_r, 0);
        check("t6_async_addr", o_mem_addr, 0);
        check("t6_async_rdata", {o_if_rdata, o_d_rdata}, 0);
        check("t6_async_valids", {o_if_valid, o_d_valid, o_err}, 0);
        i_d_req  = 1'b0;
        mem_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (o_mem_req || o_if_valid || o_d_valid) cnt++;
        end
        check("t6_quiet_after", cnt, 0);

        repeat (2) @(negedge clk);
        check("queues_drained", iss_q.size() + d_q.size() + if_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
